// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the symmetric FIR datapath
package fir_pkg;

  // Frame length shared by frame_serializer and pingpong_buf; both sides must agree.
  localparam int FIR_MAX_COUNT = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_SWITCH
  } ser_state_t;

endpackage

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - parallel-to-serial framer feeding pingpong_buf
module frame_serializer
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int MAX_COUNT = FIR_MAX_COUNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              switch,
  output logic              underrun
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(MAX_COUNT - 1);

  // A frame must hold a whole number of words, otherwise reload and frame end drift apart.
  if ((MAX_COUNT % DATA_W) != 0 || MAX_COUNT < DATA_W) begin : g_bad_cfg
    $error("frame_serializer: MAX_COUNT must be a non-zero multiple of DATA_W");
  end

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic              underrun_q, underrun_d;
  logic              s_ready_q;
  logic              accept;

  assign s_ready  = s_ready_q;
  assign underrun = underrun_q;

  // Next-state, holding-register and serial output logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    bit_out     = 1'b0;
    bit_valid   = 1'b0;
    switch      = 1'b0;

    // s_ready is low whenever hold is full, so an accept never collides with a load below.
    accept = s_valid && s_ready_q;
    if (accept) begin
      hold_d      = s_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          frame_cnt_d = '0;
          state_d     = S_SHIFT;
        end
      end

      S_SHIFT: begin
        bit_out     = shift_q[DATA_W-1];
        bit_valid   = 1'b1;
        shift_d     = shift_q << 1;
        bit_cnt_d   = bit_cnt_q + BW'(1);
        frame_cnt_d = frame_cnt_q + FW'(1);
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (frame_cnt_q == FRAME_LAST) begin
            // The next word waits in hold until the switch cycle decides whether to continue.
            frame_cnt_d = '0;
            state_d     = S_SWITCH;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            // Starved mid-frame: pad with zeros so the frame length never changes.
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        end
      end

      S_SWITCH: begin
        switch      = 1'b1;
        bit_cnt_d   = '0;
        frame_cnt_d = '0;
        if (enable) begin
          state_d = S_SHIFT;
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
          end else begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any partial frame and drops the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
      s_ready_q   <= !hold_full_d;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// tb/tb_frame_serializer.sv - directed self-checking bench for frame_serializer
module tb_frame_serializer;

  localparam int DW = 4;
  localparam int MC = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          bit_out;
  logic          bit_valid;
  logic          switch;
  logic          underrun;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] feed_q[$];
  int            log_q[$];
  int            exp_q[$];
  bit            auto_feed = 1'b0;
  int            sw_seen = 0;
  int            stall_cnt = 0;

  frame_serializer #(.DATA_W(DW), .MAX_COUNT(MC)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .bit_out  (bit_out),
    .bit_valid(bit_valid),
    .switch   (switch),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_feed();
    if (auto_feed) begin
      s_valid = (feed_q.size() > 0);
      s_data  = (feed_q.size() > 0) ? feed_q[0] : '0;
    end
  endtask

  // One clock: sample handshake before the edge, observe outputs 1 time unit after it.
  task automatic tick();
    bit acc;
    acc = (s_valid === 1'b1) && (s_ready === 1'b1);
    if (s_valid === 1'b1 && s_ready === 1'b0) stall_cnt++;
    @(posedge clk);
    #1;
    if (acc && auto_feed) void'(feed_q.pop_front());
    if (acc) chk("ready_low_after_accept", s_ready, 0);
    if (bit_valid === 1'b1) log_q.push_back(int'(bit_out));
    if (switch === 1'b1) begin
      log_q.push_back(2);
      sw_seen++;
      chk("switch_cycle_quiet", {bit_valid, bit_out}, 0);
    end
    drive_feed();
  endtask

  task automatic exp_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) exp_q.push_back(int'(w[i]));
  endtask

  task automatic check_log(input string tag);
    int n;
    chk($sformatf("%s_len", tag), log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    log_q.delete();
    exp_q.delete();
  endtask

  // Run until the n-th switch pulse; optionally drop enable during that switch cycle.
  task automatic run_to_switch(input int n, input bit drop);
    int lim;
    lim = 0;
    while (sw_seen < n && lim < 100) begin
      tick();
      lim++;
    end
    if (drop) enable = 1'b0;
    chk("switch_reached", (sw_seen >= n), 1);
  endtask

  initial begin
    // Reset with stimulus active: nothing may be accepted and all outputs stay quiet.
    rst     = 1'b1;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 4'h9;
    repeat (3) begin
      tick();
      chk("rst_s_ready", s_ready, 0);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_switch", switch, 0);
      chk("rst_underrun", underrun, 0);
    end
    rst     = 1'b0;
    s_valid = 1'b0;
    tick();
    chk("ready_after_release", s_ready, 1);
    tick();
    tick();
    chk("no_word_kept_from_reset", bit_valid, 0);
    log_q.delete();

    // Normal frames with first-word latency.
    auto_feed = 1'b1;
    sw_seen   = 0;
    feed_q    = '{4'hF, 4'h0, 4'hA, 4'h5};
    drive_feed();
    tick();
    chk("lat_accept_edge_quiet", bit_valid, 0);
    tick();
    chk("lat_msb_valid", bit_valid, 1);
    chk("lat_msb_value", bit_out, 1);
    run_to_switch(2, 1'b1);
    chk("normal_no_underrun", underrun, 0);
    exp_word(4'hF); exp_word(4'h0); exp_q.push_back(2);
    exp_word(4'hA); exp_word(4'h5); exp_q.push_back(2);
    check_log("normal");
    tick();
    chk("normal_idle_valid", bit_valid, 0);
    chk("normal_idle_underrun", underrun, 0);

    // Backpressure: four words queued at once, s_valid held high.
    sw_seen   = 0;
    stall_cnt = 0;
    enable    = 1'b1;
    feed_q    = '{4'h9, 4'h6, 4'h3, 4'hE};
    drive_feed();
    run_to_switch(2, 1'b1);
    exp_word(4'h9); exp_word(4'h6); exp_q.push_back(2);
    exp_word(4'h3); exp_word(4'hE); exp_q.push_back(2);
    check_log("backpressure");
    chk("bp_stalled", (stall_cnt > 0), 1);
    chk("bp_all_consumed", feed_q.size(), 0);
    chk("bp_no_underrun", underrun, 0);
    tick();

    // Enable drop while bit 3 is on the line: frame still completes.
    sw_seen = 0;
    enable  = 1'b1;
    feed_q  = '{4'h7, 4'hB};
    drive_feed();
    for (int k = 0; k < 20 && log_q.size() < 3; k++) tick();
    enable = 1'b0;
    run_to_switch(1, 1'b0);
    exp_word(4'h7); exp_word(4'hB); exp_q.push_back(2);
    check_log("enable_drop");
    tick();
    chk("ed_idle_valid", bit_valid, 0);
    chk("ed_idle_switch", switch, 0);
    tick();
    chk("ed_idle_valid2", bit_valid, 0);
    chk("ed_no_underrun", underrun, 0);

    // Underrun: one word then starvation; padding keeps the cadence and the flag sticks.
    sw_seen = 0;
    enable  = 1'b1;
    feed_q  = '{4'hC};
    drive_feed();
    run_to_switch(1, 1'b0);
    chk("ur_flag_set", underrun, 1);
    run_to_switch(2, 1'b1);
    exp_word(4'hC); exp_word(4'h0); exp_q.push_back(2);
    exp_word(4'h0); exp_word(4'h0); exp_q.push_back(2);
    check_log("underrun");
    tick();
    chk("ur_sticky", underrun, 1);
    chk("ur_idle_valid", bit_valid, 0);

    // Mid-frame reset during bit 5, then a fresh frame.
    sw_seen = 0;
    enable  = 1'b1;
    feed_q  = '{4'h5, 4'hA, 4'h3, 4'hC};
    drive_feed();
    for (int k = 0; k < 30 && log_q.size() < 5; k++) tick();
    rst = 1'b1;
    feed_q.delete();
    drive_feed();
    tick();
    chk("mr_bit_valid", bit_valid, 0);
    chk("mr_switch", switch, 0);
    chk("mr_bit_out", bit_out, 0);
    chk("mr_underrun", underrun, 0);
    chk("mr_s_ready", s_ready, 0);
    rst = 1'b0;
    exp_word(4'h5); exp_q.push_back(1);
    check_log("mr_partial");
    chk("mr_no_switch", sw_seen, 0);
    feed_q = '{4'h3, 4'hC};
    drive_feed();
    run_to_switch(1, 1'b1);
    exp_word(4'h3); exp_word(4'hC); exp_q.push_back(2);
    check_log("mr_restart");
    chk("mr_restart_underrun", underrun, 0);
    tick();
    chk("mr_idle_valid", bit_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
